// File: rtl/bus_master_port.sv
// Bus master port: latches one command and serialises address and write data LSB first,
// assembling serial read data into words. Define BUS_TIMEOUT_EN to abort stalled transfers.
module bus_master_port #(
   parameter int SLAVE_LEN      = 2,
   parameter int ADDR_LEN       = 12,
   parameter int DATA_LEN       = 8,
   parameter int BURST_LEN      = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_LEN-1:0]  address,
   input  logic [DATA_LEN-1:0]  data,
   input  logic [BURST_LEN-1:0] burst_num,
   input  logic [SLAVE_LEN-1:0] slave_select,
   input  logic [1:0]           instruction,
   output logic                 tx_done,
   output logic                 rx_done,
   output logic                 new_rx,
   output logic [DATA_LEN-1:0]  new_data,
   output logic                 bus_err,
   output logic                 bus_req,
   input  logic                 bus_grant,
   output logic [SLAVE_LEN-1:0] m_sel,
   output logic                 m_mode,
   output logic                 m_valid,
   output logic                 m_dout,
   input  logic                 s_ready,
   input  logic                 s_valid,
   input  logic                 s_din
);

   localparam int MAXLEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
   localparam int CW     = $clog2(MAXLEN + 1);
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_LEN);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_LEN);
   localparam logic [CW-1:0] RD_LAST   = CW'(DATA_LEN - 1);

   typedef enum logic [2:0] {
      IDLE, REQ, ADDR_RDY, ADDR, DATA_RDY, WDATA, RDATA, DONE
   } state_t;

   state_t               state_q;
   logic                 instr_prev_q;
   logic                 rd_q;
   logic [ADDR_LEN-1:0]  addr_sh_q;
   logic [DATA_LEN-1:0]  data_q;
   logic [DATA_LEN-1:0]  wsh_q;
   logic [DATA_LEN-1:0]  rsh_q;
   logic [DATA_LEN-1:0]  new_data_q;
   logic [BURST_LEN-1:0] burst_q;
   logic [CW-1:0]        bit_q;
   logic                 bus_req_q;
   logic [SLAVE_LEN-1:0] m_sel_q;
   logic                 m_mode_q;
   logic                 m_valid_q;
   logic                 m_dout_q;
   logic                 tx_done_q;
   logic                 rx_done_q;
   logic                 new_rx_q;

   logic                 accept;
   logic                 tmo_hit;
   logic [DATA_LEN-1:0]  rword_d;

   assign accept  = instruction[1] && !instr_prev_q;
   assign rword_d = {s_din, rsh_q[DATA_LEN-1:1]};

   always_ff @(posedge clk) begin
      // The edge detector keeps sampling through reset so a command held across reset never fires.
      instr_prev_q <= instruction[1];
      if (reset) begin
         state_q    <= IDLE;
         rd_q       <= 1'b0;
         burst_q    <= '0;
         bit_q      <= '0;
         bus_req_q  <= 1'b0;
         m_sel_q    <= '0;
         m_mode_q   <= 1'b0;
         m_valid_q  <= 1'b0;
         m_dout_q   <= 1'b0;
         tx_done_q  <= 1'b0;
         rx_done_q  <= 1'b0;
         new_rx_q   <= 1'b0;
         new_data_q <= '0;
      end else begin
         tx_done_q <= 1'b0;
         rx_done_q <= 1'b0;
         new_rx_q  <= 1'b0;
         if (tmo_hit) begin
            state_q   <= DONE;
            tx_done_q <= ~rd_q;
            rx_done_q <= rd_q;
         end else begin
            case (state_q)
               IDLE: begin
                  if (accept) begin
                     state_q   <= REQ;
                     bus_req_q <= 1'b1;
                     m_sel_q   <= slave_select;
                     m_mode_q  <= ~instruction[0];
                     rd_q      <= instruction[0];
                     addr_sh_q <= address;
                     data_q    <= data;
                     burst_q   <= (burst_num == '0) ? BURST_LEN'(1) : burst_num;
                  end
               end
               REQ: begin
                  if (bus_grant) state_q <= ADDR_RDY;
               end
               ADDR_RDY: begin
                  if (s_ready) begin
                     state_q   <= ADDR;
                     m_valid_q <= 1'b1;
                     m_dout_q  <= addr_sh_q[0];
                     addr_sh_q <= addr_sh_q >> 1;
                     bit_q     <= CW'(1);
                  end
               end
               ADDR: begin
                  if (bit_q == ADDR_LAST) begin
                     state_q   <= rd_q ? RDATA : DATA_RDY;
                     m_valid_q <= 1'b0;
                     m_dout_q  <= 1'b0;
                     bit_q     <= '0;
                  end else begin
                     m_dout_q  <= addr_sh_q[0];
                     addr_sh_q <= addr_sh_q >> 1;
                     bit_q     <= bit_q + CW'(1);
                  end
               end
               DATA_RDY: begin
                  if (s_ready) begin
                     state_q   <= WDATA;
                     m_valid_q <= 1'b1;
                     m_dout_q  <= data_q[0];
                     wsh_q     <= data_q >> 1;
                     bit_q     <= CW'(1);
                  end
               end
               WDATA: begin
                  if (bit_q == DATA_LAST) begin
                     m_valid_q <= 1'b0;
                     m_dout_q  <= 1'b0;
                     bit_q     <= '0;
                     burst_q   <= burst_q - BURST_LEN'(1);
                     if (burst_q == BURST_LEN'(1)) begin
                        state_q   <= DONE;
                        tx_done_q <= 1'b1;
                     end else begin
                        state_q <= DATA_RDY;
                     end
                  end else begin
                     m_dout_q <= wsh_q[0];
                     wsh_q    <= wsh_q >> 1;
                     bit_q    <= bit_q + CW'(1);
                  end
               end
               RDATA: begin
                  if (s_valid) begin
                     rsh_q <= rword_d;
                     if (bit_q == RD_LAST) begin
                        bit_q      <= '0;
                        new_data_q <= rword_d;
                        new_rx_q   <= 1'b1;
                        burst_q    <= burst_q - BURST_LEN'(1);
                        if (burst_q == BURST_LEN'(1)) begin
                           state_q   <= DONE;
                           rx_done_q <= 1'b1;
                        end
                     end else begin
                        bit_q <= bit_q + CW'(1);
                     end
                  end
               end
               DONE: begin
                  state_q   <= IDLE;
                  bus_req_q <= 1'b0;
                  m_sel_q   <= '0;
                  m_mode_q  <= 1'b0;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_q;
   logic          bus_err_q;
   logic          waiting;
   logic          progress;

   always_comb begin
      waiting  = 1'b0;
      progress = 1'b0;
      case (state_q)
         REQ:               begin waiting = 1'b1; progress = bus_grant; end
         ADDR_RDY, DATA_RDY: begin waiting = 1'b1; progress = s_ready;   end
         RDATA:             begin waiting = 1'b1; progress = s_valid;   end
         default:           ;
      endcase
   end

   assign tmo_hit = waiting && !progress && (tmo_q == TMO_LAST);

   // Counts consecutive stalled cycles; any progress or leaving a wait state restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= tmo_hit;
         if (!waiting || progress || tmo_hit) tmo_q <= '0;
         else                                 tmo_q <= tmo_q + TW'(1);
      end
   end

   assign bus_err = bus_err_q;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
   assign bus_err = 1'b0;
`endif

   assign tx_done  = tx_done_q;
   assign rx_done  = rx_done_q;
   assign new_rx   = new_rx_q;
   assign new_data = new_data_q;
   assign bus_req  = bus_req_q;
   assign m_sel    = m_sel_q;
   assign m_mode   = m_mode_q;
   assign m_valid  = m_valid_q;
   assign m_dout   = m_dout_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Randomised bench for bus_master_port: a transaction-level model predicts the serial stream,
// read words, done pulses and write latency. Define BUS_TIMEOUT_EN to cover the stall timeout.
`timescale 1ns/1ps
module tb_bus_master_port;
   localparam int SLAVE_LEN = 2;
   localparam int ADDR_LEN  = 12;
   localparam int DATA_LEN  = 8;
   localparam int BURST_LEN = 12;
`ifdef BUS_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 255;
`endif
   localparam int LIMIT = 40000;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [ADDR_LEN-1:0]  address;
   logic [DATA_LEN-1:0]  data;
   logic [BURST_LEN-1:0] burst_num;
   logic [SLAVE_LEN-1:0] slave_select;
   logic [1:0]           instruction;
   logic                 tx_done, rx_done, new_rx, bus_err, bus_req;
   logic [DATA_LEN-1:0]  new_data;
   logic                 bus_grant;
   logic [SLAVE_LEN-1:0] m_sel;
   logic                 m_mode, m_valid, m_dout;
   logic                 s_ready, s_valid, s_din;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [DATA_LEN-1:0] rd_plan[$];

   bus_master_port #(
      .SLAVE_LEN(SLAVE_LEN), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN),
      .BURST_LEN(BURST_LEN), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .data(data), .burst_num(burst_num),
      .slave_select(slave_select), .instruction(instruction), .tx_done(tx_done),
      .rx_done(rx_done), .new_rx(new_rx), .new_data(new_data), .bus_err(bus_err),
      .bus_req(bus_req), .bus_grant(bus_grant), .m_sel(m_sel), .m_mode(m_mode),
      .m_valid(m_valid), .m_dout(m_dout), .s_ready(s_ready), .s_valid(s_valid), .s_din(s_din)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int write_latency(input int b, input int gdly);
      return 2 + ADDR_LEN + b * (1 + DATA_LEN) + gdly;
   endfunction

   // One complete transaction, starting and ending on a falling edge. exp_lat < 0 skips latency.
   task automatic run_txn(input logic [ADDR_LEN-1:0] a, input logic [DATA_LEN-1:0] d,
                          input logic [BURST_LEN-1:0] bn, input logic [SLAVE_LEN-1:0] sl,
                          input bit rd, input int gdly, input bit rgaps, input bit vgaps,
                          input int rlow, input int exp_lat);
      bit exp_bits[$];
      bit got_bits[$];
      bit slv_bits[$];
      logic [DATA_LEN-1:0] exp_words[$];
      logic [DATA_LEN-1:0] got_words[$];
      logic [DATA_LEN-1:0] w;
      int b, acc, lat, n, bit_err, word_err, side_err, addr_seen;
      bit done, hold, last_with_done;
      b = (bn == '0) ? 1 : int'(bn);
      bit_err = 0; word_err = 0; side_err = 0; addr_seen = 0; lat = -1;
      done = 0; last_with_done = 0; hold = 1'($urandom % 2);
      for (int i = 0; i < ADDR_LEN; i++) exp_bits.push_back(a[i]);
      if (!rd) begin
         for (int k = 0; k < b; k++)
            for (int i = 0; i < DATA_LEN; i++) exp_bits.push_back(d[i]);
      end else begin
         for (int k = 0; k < b; k++) begin
            w = (rd_plan.size() > 0) ? rd_plan.pop_front() : DATA_LEN'($urandom);
            exp_words.push_back(w);
            for (int i = 0; i < DATA_LEN; i++) slv_bits.push_back(w[i]);
         end
      end
      rd_plan.delete();

      instruction = 2'b00; bus_grant = 0; s_ready = 0; s_valid = 0; s_din = 0;
      @(negedge clk);
      address = a; data = d; burst_num = bn; slave_select = sl; instruction = {1'b1, rd};
      @(negedge clk);
      acc = cyc;
      check("req_on", {31'b0, bus_req}, 1);
      address = ADDR_LEN'($urandom); data = DATA_LEN'($urandom);
      burst_num = BURST_LEN'($urandom); slave_select = SLAVE_LEN'($urandom);
      instruction = hold ? {1'b1, 1'($urandom)} : 2'b00;
      n = 1;
      while (!done && n < LIMIT) begin
         if (m_valid) begin
            got_bits.push_back(m_dout);
            if (addr_seen < ADDR_LEN) addr_seen++;
            if (n <= gdly) side_err++;
         end else if (m_dout !== 1'b0) side_err++;
         if (bus_req !== 1'b1 || m_sel !== sl || m_mode !== !rd) side_err++;
         if (bus_err !== 1'b0) side_err++;
         if (rd ? tx_done : rx_done) side_err++;
         if (new_rx) begin
            got_words.push_back(new_data);
            if (rx_done) last_with_done = 1;
         end
         if (tx_done || rx_done) begin
            done = 1;
            lat = cyc - acc;
         end
         bus_grant = (n > gdly);
         s_ready = (n > rlow) && (!rgaps || ($urandom % 4 != 0));
         s_din = 1'($urandom);
         s_valid = 0;
         if (rd && addr_seen == ADDR_LEN && !m_valid && slv_bits.size() > 0) begin
            s_valid = !vgaps || ($urandom % 3 != 0);
            if (s_valid) s_din = slv_bits.pop_front();
         end
         @(negedge clk);
         n++;
      end
      check("done_seen", {31'b0, done}, 1);
      check("bits_len", 32'(got_bits.size()), 32'(exp_bits.size()));
      for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++)
         if (got_bits[i] != exp_bits[i]) bit_err++;
      check("bits_val", 32'(bit_err), 0);
      check("side", 32'(side_err), 0);
      if (rd) begin
         check("words_n", 32'(got_words.size()), 32'(b));
         for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
            if (got_words[i] !== exp_words[i]) word_err++;
         check("words_val", 32'(word_err), 0);
         check("newrx_last", {31'b0, last_with_done}, 1);
      end
      if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
      check("release", {28'b0, bus_req, m_mode, m_valid, m_dout}, 0);
      check("release_sel", 32'(m_sel), 0);
      if (rd && exp_words.size() > 0) check("new_data_hold", 32'(new_data), 32'(exp_words[$]));
      instruction = 2'b00;
   endtask

   int  tx_cnt, req_rise, bad;
   bit  prev_req, seen;
   logic err_at;

   initial begin
      reset = 1; instruction = 0; address = 0; data = 0; burst_num = 0; slave_select = 0;
      bus_grant = 0; s_ready = 0; s_valid = 0; s_din = 0;
      repeat (3) @(negedge clk);
      check("rst_ctl", {23'b0, bus_req, m_valid, m_dout, tx_done, rx_done, new_rx, bus_err, m_mode, 1'b0}, 0);
      check("rst_sel", 32'(m_sel), 0);
      check("rst_data", 32'(new_data), 0);
      reset = 0;
      @(negedge clk);

      // Directed write: address 0x005, data 0xA3, burst 0.
      run_txn(12'h005, 8'hA3, 12'd0, 2'd2, 0, 0, 0, 0, 0, 23);
      // Read burst of three words with gapped s_valid.
      rd_plan = '{8'h11, 8'h22, 8'h33};
      run_txn(12'h7E1, 8'h00, 12'd3, 2'd1, 1, 0, 0, 1, 0, -1);
      // Grant withheld for ten cycles.
      run_txn(12'hA5C, 8'h3C, 12'd2, 2'd3, 0, 10, 0, 0, 0, write_latency(2, 10));

      // Held instruction only triggers once.
      instruction = 0; @(negedge clk);
      address = 12'h123; data = 8'h45; burst_num = 1; slave_select = 0;
      instruction = 2'b10; bus_grant = 1; s_ready = 1; s_valid = 0;
      tx_cnt = 0; req_rise = 0; prev_req = bus_req;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_done) tx_cnt++;
         if (bus_req && !prev_req) req_rise++;
         prev_req = bus_req;
      end
      check("held_tx", 32'(tx_cnt), 1);
      check("held_req", 32'(req_rise), 1);
      instruction = 0;

      // Reset in the middle of the write data phase.
      @(negedge clk);
      address = 12'h3C5; data = 8'h96; burst_num = 1; slave_select = 1;
      instruction = 2'b10; bus_grant = 1; s_ready = 1;
      @(negedge clk);
      instruction = 0;
      repeat (17) @(negedge clk);
      check("mid_wdata", {31'b0, m_valid}, 1);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("abort_ctl", {24'b0, bus_req, m_valid, m_dout, tx_done, rx_done, new_rx, bus_err, m_mode}, 0);
      check("abort_sel", 32'(m_sel), 0);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tx_done || bus_req) bad++;
      end
      check("abort_quiet", 32'(bad), 0);
      run_txn(12'h0F0, 8'h5A, 12'd1, 2'd2, 0, 0, 0, 0, 0, 23);

`ifndef BUS_TIMEOUT_EN
      // Long s_ready stall without timeout support simply waits.
      run_txn(12'h555, 8'hC3, 12'd1, 2'd1, 0, 0, 0, 0, 300, -1);
`endif

      // Randomised transactions.
      for (int t = 0; t < 24; t++) begin
         logic [ADDR_LEN-1:0]  ra;
         logic [DATA_LEN-1:0]  rdat;
         logic [BURST_LEN-1:0] rb;
         bit rrd, rg;
         int gd, elat;
         ra = ADDR_LEN'($urandom); rdat = DATA_LEN'($urandom);
         rb = BURST_LEN'($urandom_range(0, 4));
         rrd = 1'($urandom); rg = 1'($urandom); gd = $urandom_range(0, 5);
         elat = (!rrd && !rg) ? write_latency((rb == 0) ? 1 : int'(rb), gd) : -1;
         run_txn(ra, rdat, rb, SLAVE_LEN'($urandom), rrd, gd, rg, 1'($urandom), 0, elat);
      end

      // Maximum burst length.
      run_txn(12'hABC, 8'h69, 12'd4095, 2'd1, 0, 0, 0, 0, 0, write_latency(4095, 0));

`ifdef BUS_TIMEOUT_EN
      // s_ready stuck low forces completion with bus_err.
      instruction = 0; @(negedge clk);
      address = 12'h0AA; data = 8'h11; burst_num = 1; slave_select = 1;
      instruction = 2'b10; bus_grant = 1; s_ready = 0;
      seen = 0; err_at = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         instruction = 0;
         if (tx_done) begin
            seen = 1;
            err_at = bus_err;
         end
      end
      check("tmo_done", {31'b0, seen}, 1);
      check("tmo_err", {31'b0, err_at}, 1);
      @(negedge clk);
      check("tmo_idle", {29'b0, bus_req, bus_err, tx_done}, 0);
      s_ready = 1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
